chunk_pack: RTL

Packs a stream of narrow chunks into one wide word. It is the write-side counterpart of the indexed slice-select used on the wide datapaths, such as the 128-bit key/nonce and 320-bit state buses. Chunks arrive on a valid/ready interface, are inserted at an auto-incrementing chunk index, and the completed wide word is presented on a second valid/ready interface. The block sits between the narrow host/bus side and the wide cipher-core inputs.

---
 rtl/chunk_pack.sv | 122 ++++++++++++
 1 files changed

// File: rtl/chunk_pack.sv
// chunk_pack: assembles a stream of narrow chunks into one wide word.
// Chunks land at an auto-incrementing slot index. The finished word is held on
// a valid/ready output until it is taken. When the held word is taken, the next
// word can start in the same cycle, so streaming runs without bubbles.
module chunk_pack #(
    parameter int WIDE_WIDTH  = 128,
    parameter int CHUNK_WIDTH = 32
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [CHUNK_WIDTH-1:0]                          in_data,
    input  logic                                            in_valid,
    input  logic                                            in_last,
    output logic                                            in_ready,
    output logic [WIDE_WIDTH-1:0]                           out_data,
    output logic [$clog2(WIDE_WIDTH/CHUNK_WIDTH):0]         out_count,
    output logic                                            out_valid,
    input  logic                                            out_ready
);

    localparam int N     = WIDE_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    if ((WIDE_WIDTH % CHUNK_WIDTH) != 0 || (WIDE_WIDTH / CHUNK_WIDTH) < 2) begin : g_param_check
        $error("chunk_pack: WIDE_WIDTH must be a multiple of CHUNK_WIDTH with at least two chunks");
    end

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q,   idx_d;
    logic [WIDE_WIDTH-1:0]   buf_q,   buf_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;

    logic in_hs;
    logic out_hs;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // State register: synchronous reset clears the partial word and the index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            idx_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: indexed chunk insertion, word completion, and HOLD exit with same-cycle restart.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        case (state_q)
            FILL: begin
                if (in_hs) begin
                    buf_d[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] = in_data;
                    if (idx_q == IDX_LAST || in_last) begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(idx_q) + CNT_W'(1);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_hs) begin
                    // The held word leaves: start the next word from a clean buffer.
                    buf_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = FILL;
                    // in_ready follows out_ready here, so an input handshake implies out_hs.
                    if (in_hs) begin
                        buf_d[CHUNK_WIDTH-1:0] = in_data;
                        if (in_last) begin
                            state_d = HOLD;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            idx_d = IDX_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Outputs: reset forces everything to zero; HOLD presents the word and passes out_ready to in_ready.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = buf_q;
        out_count = cnt_q;
        if (reset) begin
            out_data  = '0;
            out_count = '0;
        end else if (state_q == HOLD) begin
            out_valid = 1'b1;
            in_ready  = out_ready;
        end else begin
            in_ready = 1'b1;
        end
    end

endmodule
